// File: rtl/coh_ctrl_mp.sv
`default_nettype none
// coh_ctrl_mp: N-CPU snoop coherence controller and shared RAM arbiter.
// Revision 1.0
module coh_ctrl_mp #(
  parameter int NCPU   = 4,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NCPU-1:0]          iREN,
  input  logic [NCPU*ADDR_W-1:0]   iaddr,
  output logic [NCPU-1:0]          iwait,
  output logic [NCPU*WORD_W-1:0]   iload,
  input  logic [NCPU-1:0]          dREN,
  input  logic [NCPU-1:0]          dWEN,
  input  logic [NCPU*ADDR_W-1:0]   daddr,
  input  logic [NCPU*WORD_W-1:0]   dstore,
  output logic [NCPU-1:0]          dwait,
  output logic [NCPU*WORD_W-1:0]   dload,
  input  logic [NCPU-1:0]          cctrans,
  input  logic [NCPU-1:0]          ccwrite,
  output logic [NCPU-1:0]          ccwait,
  output logic [NCPU-1:0]          ccinv,
  output logic [NCPU*ADDR_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic                     ram_ready
);

  localparam int IW = (NCPU > 1) ? $clog2(NCPU) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SNOOP = 2'd1;
  localparam logic [1:0] S_C2C   = 2'd2;
  localparam logic [1:0] S_RAMRD = 2'd3;

  logic [1:0]    state, state_n;
  logic [IW-1:0] req, req_n, src, src_n, drr, drr_n, irr, irr_n;

  logic [ADDR_W-1:0] iaddr_a [NCPU];
  logic [ADDR_W-1:0] daddr_a [NCPU];
  logic [WORD_W-1:0] dstore_a[NCPU];
  logic [WORD_W-1:0] iload_a [NCPU];
  logic [WORD_W-1:0] dload_a [NCPU];
  logic [ADDR_W-1:0] snoop_a [NCPU];

  for (genvar k = 0; k < NCPU; k++) begin : g_cpu
    assign iaddr_a[k]  = iaddr[k*ADDR_W +: ADDR_W];
    assign daddr_a[k]  = daddr[k*ADDR_W +: ADDR_W];
    assign dstore_a[k] = dstore[k*WORD_W +: WORD_W];
    assign iload[k*WORD_W +: WORD_W]       = iload_a[k];
    assign dload[k*WORD_W +: WORD_W]       = dload_a[k];
    assign ccsnoopaddr[k*ADDR_W +: ADDR_W] = snoop_a[k];
  end

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(NCPU - 1)) ? '0 : x + 1'b1;
  endfunction

  // Returns {found, index} of the first set bit scanning cyclically from p.
  function automatic logic [IW:0] rr_pick(input logic [NCPU-1:0] v, input logic [IW-1:0] p);
    logic [IW-1:0] c, r;
    logic          f;
    c = p;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < NCPU; i++) begin
      if (!f && v[c]) begin
        f = 1'b1;
        r = c;
      end
      c = inc(c);
    end
    return {f, r};
  endfunction

  function automatic logic [IW:0] lowest(input logic [NCPU-1:0] v);
    logic [IW:0] r;
    r = '0;
    for (int i = NCPU - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, IW'(i)};
    end
    return r;
  endfunction

  logic [IW:0] cc_pick, if_pick, wb_pick, sup_pick;
  assign cc_pick  = rr_pick(cctrans, drr);
  assign if_pick  = rr_pick(iREN, irr);
  assign wb_pick  = lowest(dWEN);
  assign sup_pick = lowest(ccwrite & ~(NCPU'(1) << req));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      req   <= '0;
      src   <= '0;
      drr   <= '0;
      irr   <= '0;
    end else begin
      state <= state_n;
      req   <= req_n;
      src   <= src_n;
      drr   <= drr_n;
      irr   <= irr_n;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = req;
    src_n   = src;
    drr_n   = drr;
    irr_n   = irr;
    case (state)
      S_IDLE: begin
        if (cc_pick[IW]) begin
          req_n   = cc_pick[IW-1:0];
          drr_n   = inc(cc_pick[IW-1:0]);
          state_n = S_SNOOP;
        end else if (!wb_pick[IW] && if_pick[IW] && ram_ready) begin
          irr_n = inc(if_pick[IW-1:0]);
        end
      end
      S_SNOOP: begin
        if (!cctrans[req]) begin
          state_n = S_IDLE;
        end else if (sup_pick[IW]) begin
          src_n   = sup_pick[IW-1:0];
          state_n = S_C2C;
        end else begin
          state_n = S_RAMRD;
        end
      end
      default: begin
        if (!cctrans[req]) state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int j = 0; j < NCPU; j++) begin
      iload_a[j] = '0;
      dload_a[j] = '0;
      snoop_a[j] = '0;
    end
    if (state == S_IDLE) begin
      if (cc_pick[IW]) begin
        ccwait = ~(NCPU'(1) << cc_pick[IW-1:0]);
      end else if (wb_pick[IW]) begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_a[wb_pick[IW-1:0]];
        ramstore = dstore_a[wb_pick[IW-1:0]];
        dwait[wb_pick[IW-1:0]] = !ram_ready;
      end else if (if_pick[IW]) begin
        ramREN  = 1'b1;
        ramaddr = iaddr_a[if_pick[IW-1:0]];
        if (ram_ready) begin
          iwait[if_pick[IW-1:0]]   = 1'b0;
          iload_a[if_pick[IW-1:0]] = ramload;
        end
      end
    end else begin
      for (int j = 0; j < NCPU; j++) begin
        if (IW'(j) != req) begin
          snoop_a[j] = daddr_a[req];
          ccwait[j]  = 1'b1;
          ccinv[j]   = ccwrite[req];
        end
      end
      if (state == S_C2C) begin
        dload_a[req] = dstore_a[src];
        ramWEN       = dWEN[src];
        ramaddr      = daddr_a[req];
        ramstore     = dstore_a[src];
        dwait[req]   = !ram_ready;
        dwait[src]   = !ram_ready;
      end else if (state == S_RAMRD) begin
        ramaddr      = daddr_a[req];
        ramREN       = dREN[req] & !dWEN[req];
        ramWEN       = dWEN[req];
        ramstore     = dstore_a[req];
        dload_a[req] = ramload;
        // A ready pulse with no strobe raised does not complete anything.
        dwait[req]   = !(ram_ready && (dREN[req] || dWEN[req]));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coh_ctrl_mp.sv
`default_nettype none
// tb_coh_ctrl_mp: directed self-checking bench for coh_ctrl_mp with NCPU=4.
module tb_coh_ctrl_mp;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int WW = 32;

  logic CLK = 1'b0;
  logic RST;
  logic [N-1:0] iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [N*AW-1:0] iaddr, daddr, ccsnoopaddr;
  logic [N*WW-1:0] iload, dstore, dload;
  logic ramREN, ramWEN, ram_ready;
  logic [AW-1:0] ramaddr;
  logic [WW-1:0] ramstore, ramload;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  coh_ctrl_mp #(.NCPU(N), .ADDR_W(AW), .WORD_W(WW)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  // Advance past a clock edge; inputs change here and outputs settle 1 ns later.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;
    cyc(); cyc();
    RST = 1'b0;
    cyc();
    iREN = 4'b0001; ram_ready = 1'b1; ramload = 32'h1234;
    settle();
    checks++; if (iwait !== 4'b1110) begin errors++; $display("FAIL rst_pre_ifetch: iwait=%b want 1110", iwait); end
    cyc();
    iREN = '0; ram_ready = 1'b0;
    cctrans = 4'b0100; ccwrite = 4'b0100;
    daddr[2*AW +: AW] = 32'h100; dstore[0 +: WW] = 32'hAAAA0000;
    settle();
    checks++; if (ccwait !== 4'b1011) begin errors++; $display("FAIL rst_pre_grant: ccwait=%b want 1011", ccwait); end
    cyc();
    ccwrite = 4'b0101;
    cyc();
    settle();
    checks++; if (dload[2*WW +: WW] !== 32'hAAAA0000) begin errors++; $display("FAIL rst_pre_c2c: dload2=%h want aaaa0000", dload[2*WW +: WW]); end
    RST = 1'b1; cctrans = '0; ccwrite = '0;
    cyc();
    RST = 1'b0;
    settle();
    checks++; if (iwait !== 4'b1111 || dwait !== 4'b1111) begin errors++; $display("FAIL rst_waits: iwait=%b dwait=%b want 1111 1111", iwait, dwait); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ccwait !== 4'b0000) begin errors++; $display("FAIL rst_strobes: ren=%b wen=%b ccwait=%b want 0 0 0000", ramREN, ramWEN, ccwait); end
    cctrans = 4'b1111;
    settle();
    checks++; if (ccwait !== 4'b1110) begin errors++; $display("FAIL rst_drr: ccwait=%b want 1110", ccwait); end
    cctrans = '0; iREN = 4'b1111; ram_ready = 1'b1;
    settle();
    checks++; if (iwait !== 4'b1110) begin errors++; $display("FAIL rst_irr: iwait=%b want 1110", iwait); end
    iREN = '0; ram_ready = 1'b0;
    settle();
  endtask

  task automatic test_ifetch_rr();
    logic [N-1:0] want;
    for (int k = 0; k < N; k++) iaddr[k*AW +: AW] = 32'h2000 + 32'(k * 4);
    iREN = 4'b1111; ram_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      ramload = 32'h1000 + 32'(c);
      settle();
      want = ~(4'b0001 << (c % 4));
      checks++; if (iwait !== want) begin errors++; $display("FAIL ifetch_rr_%0d: iwait=%b want %b", c, iwait, want); end
      checks++; if (iload[(c % 4)*WW +: WW] !== ramload || ramaddr !== 32'h2000 + 32'((c % 4) * 4)) begin
        errors++; $display("FAIL ifetch_data_%0d: iload=%h addr=%h want %h %h", c, iload[(c % 4)*WW +: WW], ramaddr, ramload, 32'h2000 + 32'((c % 4) * 4));
      end
      cyc();
    end
    // irr now 1; hold CPU1 while RAM is not ready.
    iREN = 4'b0110; ram_ready = 1'b0;
    settle();
    checks++; if (iwait !== 4'b1111 || ramREN !== 1'b1 || ramaddr !== 32'h2004) begin errors++; $display("FAIL ifetch_hold: iwait=%b ren=%b addr=%h want 1111 1 2004", iwait, ramREN, ramaddr); end
    cyc();
    ram_ready = 1'b1;
    settle();
    checks++; if (iwait !== 4'b1101) begin errors++; $display("FAIL ifetch_hold_done: iwait=%b want 1101", iwait); end
    cyc();
    iREN = '0; ram_ready = 1'b0;
    settle();
  endtask

  task automatic test_c2c();
    cctrans = 4'b0100; ccwrite = 4'b0100; dWEN = 4'b0001;
    daddr[2*AW +: AW] = 32'h100; daddr[0 +: AW] = 32'h500;
    dstore[0 +: WW] = 32'hDEAD0000; dstore[3*WW +: WW] = 32'hBEEF3333;
    settle();
    checks++; if (ramWEN !== 1'b0 || ccwait !== 4'b1011) begin errors++; $display("FAIL c2c_grant: wen=%b ccwait=%b want 0 1011", ramWEN, ccwait); end
    cyc();
    settle();
    checks++; if (ccinv !== 4'b1011 || ccwait !== 4'b1011) begin errors++; $display("FAIL c2c_snoop_inv: ccinv=%b ccwait=%b want 1011 1011", ccinv, ccwait); end
    checks++; if (ccsnoopaddr !== {32'h100, 32'h0, 32'h100, 32'h100}) begin errors++; $display("FAIL c2c_snoopaddr: got %h want 00000100_00000000_00000100_00000100", ccsnoopaddr); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL c2c_snoop_quiet: ren=%b wen=%b want 0 0", ramREN, ramWEN); end
    ccwrite = 4'b1101;
    cyc();
    settle();
    checks++; if (dload[2*WW +: WW] !== 32'hDEAD0000) begin errors++; $display("FAIL c2c_dload: got %h want dead0000", dload[2*WW +: WW]); end
    checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h100 || ramstore !== 32'hDEAD0000) begin errors++; $display("FAIL c2c_wb: wen=%b addr=%h data=%h want 1 100 dead0000", ramWEN, ramaddr, ramstore); end
    checks++; if (dwait !== 4'b1111 || ccinv !== 4'b1011) begin errors++; $display("FAIL c2c_stall: dwait=%b ccinv=%b want 1111 1011", dwait, ccinv); end
    ram_ready = 1'b1;
    settle();
    checks++; if (dwait !== 4'b1010) begin errors++; $display("FAIL c2c_ready: dwait=%b want 1010", dwait); end
    cctrans = '0; ccwrite = '0; dWEN = '0; ram_ready = 1'b0;
    cyc();
    settle();
    checks++; if (ccwait !== 4'b0000 || ramWEN !== 1'b0) begin errors++; $display("FAIL c2c_idle: ccwait=%b wen=%b want 0000 0", ccwait, ramWEN); end
  endtask

  task automatic test_ramrd();
    // drr is 3 here, so the scan 3,0,1 picks CPU1.
    cctrans = 4'b0010; ccwrite = '0; dREN = 4'b0010; daddr[1*AW +: AW] = 32'h240;
    settle();
    checks++; if (ccwait !== 4'b1101) begin errors++; $display("FAIL ramrd_grant: ccwait=%b want 1101", ccwait); end
    cyc();
    settle();
    checks++; if (ccinv !== 4'b0000 || ccwait !== 4'b1101) begin errors++; $display("FAIL ramrd_snoop: ccinv=%b ccwait=%b want 0000 1101", ccinv, ccwait); end
    cyc();
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h240 || dwait !== 4'b1111) begin
        errors++; $display("FAIL ramrd_wait_%0d: ren=%b wen=%b addr=%h dwait=%b want 1 0 240 1111", c, ramREN, ramWEN, ramaddr, dwait);
      end
      cyc();
    end
    ram_ready = 1'b1; ramload = 32'h55;
    settle();
    checks++; if (dwait !== 4'b1101 || dload[1*WW +: WW] !== 32'h55 || ccinv !== 4'b0000) begin
      errors++; $display("FAIL ramrd_done: dwait=%b dload1=%h ccinv=%b want 1101 55 0000", dwait, dload[1*WW +: WW], ccinv);
    end
    cctrans = '0; dREN = '0; ram_ready = 1'b0;
    cyc();
    settle();
  endtask

  task automatic test_rr_coherence();
    // drr is 2: CPU3 must win over CPU1, and the writeback waits.
    cctrans = 4'b1010; dWEN = 4'b0001; daddr[0 +: AW] = 32'h300; dstore[0 +: WW] = 32'h77;
    settle();
    checks++; if (ccwait !== 4'b0111 || ramWEN !== 1'b0) begin errors++; $display("FAIL rr_first: ccwait=%b wen=%b want 0111 0", ccwait, ramWEN); end
    cyc();
    cctrans = 4'b0010;
    cyc();
    settle();
    checks++; if (ccwait !== 4'b1101 || ramWEN !== 1'b0) begin errors++; $display("FAIL rr_second: ccwait=%b wen=%b want 1101 0", ccwait, ramWEN); end
    cyc();
    cctrans = '0;
    cyc();
    ram_ready = 1'b1;
    settle();
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300 || ramstore !== 32'h77 || dwait !== 4'b1110) begin
      errors++; $display("FAIL rr_writeback: wen=%b ren=%b addr=%h data=%h dwait=%b want 1 0 300 77 1110", ramWEN, ramREN, ramaddr, ramstore, dwait);
    end
    cyc();
    dWEN = '0; ram_ready = 1'b0;
    settle();
  endtask

  task automatic test_snoop_abort();
    // drr is 2 again; only CPU0 requests.
    cctrans = 4'b0001; dREN = 4'b0001; daddr[0 +: AW] = 32'h400;
    cyc();
    cctrans = '0; ram_ready = 1'b1;
    settle();
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ccwait !== 4'b1110) begin errors++; $display("FAIL abort_snoop: ren=%b wen=%b ccwait=%b want 0 0 1110", ramREN, ramWEN, ccwait); end
    cyc();
    settle();
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ccwait !== 4'b0000 || dwait !== 4'b1111) begin
      errors++; $display("FAIL abort_idle: ren=%b wen=%b ccwait=%b dwait=%b want 0 0 0000 1111", ramREN, ramWEN, ccwait, dwait);
    end
    dREN = '0; ram_ready = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_ifetch_rr();
    test_c2c();
    test_ramrd();
    test_rr_coherence();
    test_snoop_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
